// File: rtl/fetch_decode_buffer_pkg.sv
// -----------------------------------------------------------------------------
// fetch_decode_buffer_pkg
// Shared constants for the fetch/decode instruction buffer.
//   FD_NOP        : instruction presented to decode when no entry is valid
//   FD_FIELD_W    : width of each field of a buffered entry
//   FD_ENTRY_W    : width of one buffered entry {instr, pc, pc+1}
//   FD_*_LSB      : bit offsets of the fields inside an entry
//   FD_DEPTH      : number of buffer slots
// -----------------------------------------------------------------------------
package fetch_decode_buffer_pkg;

    localparam int unsigned FD_FIELD_W     = 32;
    localparam int unsigned FD_ENTRY_W     = 96;
    localparam int unsigned FD_INSTR_LSB   = 64;
    localparam int unsigned FD_PC_LSB      = 32;
    localparam int unsigned FD_PC1_LSB     = 0;
    localparam logic [1:0]  FD_DEPTH       = 2'd2;
    localparam logic [31:0] FD_NOP         = 32'h0000_0000;

    typedef logic [1:0] fd_count_t;

    // Assemble one buffer entry from its three fields.
    function automatic logic [FD_ENTRY_W-1:0] fd_pack_entry(
        input logic [FD_FIELD_W-1:0] instr,
        input logic [FD_FIELD_W-1:0] pc,
        input logic [FD_FIELD_W-1:0] pc1
    );
        logic [FD_ENTRY_W-1:0] entry;
        entry = '0;
        entry[FD_INSTR_LSB +: FD_FIELD_W] = instr;
        entry[FD_PC_LSB    +: FD_FIELD_W] = pc;
        entry[FD_PC1_LSB   +: FD_FIELD_W] = pc1;
        return entry;
    endfunction

endpackage

// File: rtl/fd_skid_fifo.sv
// -----------------------------------------------------------------------------
// fd_skid_fifo
// Two-deep FIFO of FD_ENTRY_W-wide entries with 1-bit wrapping pointers.
// Ports:
//   i_clk, i_rst_n  : clock, asynchronous active-low reset
//   i_push, i_data  : write i_data at the tail
//   i_pop           : remove the head (ignored when empty)
//   i_clear         : synchronous squash of all entries, wins over push/pop
//   o_count         : number of valid entries (0..2)
//   o_head          : entry at the head pointer (stale when o_count==0)
//   o_overflow      : sticky, set when a push found no free slot
// -----------------------------------------------------------------------------
module fd_skid_fifo
    import fetch_decode_buffer_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic                  i_clear,
    input  logic [FD_ENTRY_W-1:0] i_data,
    output fd_count_t             o_count,
    output logic [FD_ENTRY_W-1:0] o_head,
    output logic                  o_overflow
);

    logic [FD_ENTRY_W-1:0] r_mem [0:1];
    logic                  r_head_ptr;
    logic                  r_tail_ptr;
    fd_count_t             r_count;
    logic                  r_overflow;

    logic                  w_do_pop;
    logic                  w_has_room;
    logic                  w_do_push;
    logic                  w_drop;
    fd_count_t             w_count_nxt;

    // A pop in the same cycle frees the slot a full-buffer push needs.
    assign w_do_pop   = i_pop & ~i_clear & (r_count != 2'd0);
    assign w_has_room = (r_count != FD_DEPTH) | w_do_pop;
    assign w_do_push  = i_push & ~i_clear & w_has_room;
    assign w_drop     = i_push & ~i_clear & ~w_has_room;

    // Next occupancy from the qualified push/pop pair.
    always_comb begin
        w_count_nxt = r_count;
        if (w_do_push && !w_do_pop) begin
            w_count_nxt = r_count + 2'd1;
        end else if (!w_do_push && w_do_pop) begin
            w_count_nxt = r_count - 2'd1;
        end else begin
            w_count_nxt = r_count;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head_ptr <= 1'b0;
            r_tail_ptr <= 1'b0;
            r_count    <= 2'd0;
        end else if (i_clear) begin
            r_head_ptr <= 1'b0;
            r_tail_ptr <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_tail_ptr <= ~r_tail_ptr;
            end
            if (w_do_pop) begin
                r_head_ptr <= ~r_head_ptr;
            end
            r_count <= w_count_nxt;
        end
    end

    // Entry storage; a dropped push leaves the contents untouched.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_tail_ptr] <= i_data;
        end
    end

    // Sticky overflow flag; only reset clears it, a squash does not.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign o_count    = r_count;
    assign o_head     = r_mem[r_head_ptr];
    assign o_overflow = r_overflow;

endmodule

// File: rtl/fetch_decode_buffer.sv
// -----------------------------------------------------------------------------
// fetch_decode_buffer
// Two-entry instruction buffer between fetch and decode. An imem read issued
// in cycle N returns data in N+1; the PC pair issued with it is held in an
// in-flight register for that cycle and the three are pushed together.
// Ports:
//   i_clk, i_rst_n            : clock, asynchronous active-low reset
//   i_fetch_valid             : fetch issued an imem read this cycle
//   i_fetch_pc                : address sent to imem this cycle
//   i_fetch_incremented_pc    : i_fetch_pc + 1
//   i_q_imem                  : imem data for the previous cycle's read
//   i_flush                   : taken jump, squash everything
//   i_decode_ready            : decode accepts the head this cycle
//   o_f_d_valid               : head entry valid
//   o_f_d_instruction         : head instruction, FD_NOP when invalid
//   o_f_d_pc                  : head PC, 0 when invalid
//   o_f_d_incremented_pc      : head PC+1, 0 when invalid
//   o_buffer_full             : fetch must not issue this cycle
//   o_overflow_error          : sticky, a push arrived with no free slot
// -----------------------------------------------------------------------------
module fetch_decode_buffer
    import fetch_decode_buffer_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_fetch_valid,
    input  logic [FD_FIELD_W-1:0] i_fetch_pc,
    input  logic [FD_FIELD_W-1:0] i_fetch_incremented_pc,
    input  logic [FD_FIELD_W-1:0] i_q_imem,
    input  logic                  i_flush,
    input  logic                  i_decode_ready,
    output logic                  o_f_d_valid,
    output logic [FD_FIELD_W-1:0] o_f_d_instruction,
    output logic [FD_FIELD_W-1:0] o_f_d_pc,
    output logic [FD_FIELD_W-1:0] o_f_d_incremented_pc,
    output logic                  o_buffer_full,
    output logic                  o_overflow_error
);

    logic                  r_pending_valid;
    logic [FD_FIELD_W-1:0] r_pending_pc;
    logic [FD_FIELD_W-1:0] r_pending_pc1;

    fd_count_t             w_count;
    logic [FD_ENTRY_W-1:0] w_head;
    logic [FD_ENTRY_W-1:0] w_entry;
    logic                  w_head_valid;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_overflow;
    logic [2:0]            w_occupancy;

    // In-flight stage: remembers which PC the imem data arriving next belongs to.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending_valid <= 1'b0;
            r_pending_pc    <= '0;
            r_pending_pc1   <= '0;
        end else if (i_flush) begin
            // A read issued alongside a taken jump is wrong-path.
            r_pending_valid <= 1'b0;
        end else begin
            r_pending_valid <= i_fetch_valid;
            if (i_fetch_valid) begin
                r_pending_pc  <= i_fetch_pc;
                r_pending_pc1 <= i_fetch_incremented_pc;
            end
        end
    end

    assign w_head_valid = (w_count != 2'd0);
    assign w_pop        = w_head_valid & i_decode_ready & ~i_flush;
    assign w_push       = r_pending_valid & ~i_flush;
    assign w_entry      = fd_pack_entry(i_q_imem, r_pending_pc, r_pending_pc1);

    fd_skid_fifo u_fifo (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_push     (w_push),
        .i_pop      (w_pop),
        .i_clear    (i_flush),
        .i_data     (w_entry),
        .o_count    (w_count),
        .o_head     (w_head),
        .o_overflow (w_overflow)
    );

    // Slots claimed next cycle: buffered + in flight - leaving now. A pop
    // needs a valid head, so this never underflows.
    assign w_occupancy   = {1'b0, w_count} + {2'b00, r_pending_valid} - {2'b00, w_pop};
    assign o_buffer_full = (w_occupancy >= 3'd2);

    // Decode-facing outputs, masked so decode sees a clean NOP when empty.
    always_comb begin
        o_f_d_valid          = w_head_valid;
        o_f_d_instruction    = FD_NOP;
        o_f_d_pc             = '0;
        o_f_d_incremented_pc = '0;
        if (w_head_valid) begin
            o_f_d_instruction    = w_head[FD_INSTR_LSB +: FD_FIELD_W];
            o_f_d_pc             = w_head[FD_PC_LSB    +: FD_FIELD_W];
            o_f_d_incremented_pc = w_head[FD_PC1_LSB   +: FD_FIELD_W];
        end else begin
            o_f_d_instruction    = FD_NOP;
            o_f_d_pc             = '0;
            o_f_d_incremented_pc = '0;
        end
    end

    assign o_overflow_error = w_overflow;

endmodule
